// File: rtl/xbar_pkg.sv
// Shared definitions for the 4x4 output crossbar route scheduler.
//   XBAR_PORTS / SEL_W : crossbar size and selector width
//   sel_vec_t          : one selector per output, index 0 = output a
//   SEL_IDENTITY       : straight-through routing (a<-a .. d<-d)
//   state_e            : sequencer FSM states
package xbar_pkg;
   localparam int XBAR_PORTS = 4;
   localparam int SEL_W      = 2;

   typedef logic [SEL_W-1:0]      sel_t;
   typedef sel_t [XBAR_PORTS-1:0] sel_vec_t;

   localparam sel_vec_t SEL_IDENTITY = {2'd3, 2'd2, 2'd1, 2'd0};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PEND,
      ST_BLANK_PRE,
      ST_BLANK_POST
   } state_e;
endpackage

// File: rtl/xbar_blank_timer.sv
// Loadable 8-bit down-counter timing one blanking half-window.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load load_val_i (takes priority over counting)
//   load_val_i    : value loaded; done_o rises load_val_i cycles later
//   done_o        : counter has reached zero (holds there)
module xbar_blank_timer (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   output logic       done_o
);
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)             cnt_d = load_val_i;
      else if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= 8'd0;
      else         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == 8'd0);
endmodule

// File: rtl/xbar_route_sched.sv
// Crossbar route sequencer: host writes a shadow selector table one entry
// at a time; the table is copied to the active selectors on a frame
// boundary, centred in a blanking window with output enable low.
// Optional auto-rotate advances every shadow route by one source every
// max(rotate_period_in,1) frames and forces a commit.
//   clk_in, rst_n_in                 : clock, async active-low reset
//   cfg_valid_in / cfg_ready_out     : host write handshake
//   cfg_out_idx_in, cfg_src_in       : entry to write and its source
//   frame_sync_in                    : frame-boundary pulse
//   rotate_en_in, rotate_period_in   : auto-rotate control
//   xbar_selectors_[a..d]_out        : active selectors
//   xbar_oe_out                      : crossbar output enable
//   commit_pulse_out                 : active selectors changed this cycle
//   pending_out                      : uncommitted shadow changes exist
module xbar_route_sched
   import xbar_pkg::*;
#(
   parameter int BLANK_CYCLES = 4,
   parameter int ROT_W        = 16
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             cfg_valid_in,
   output logic             cfg_ready_out,
   input  logic [1:0]       cfg_out_idx_in,
   input  logic [1:0]       cfg_src_in,
   input  logic             frame_sync_in,
   input  logic             rotate_en_in,
   input  logic [ROT_W-1:0] rotate_period_in,
   output logic [1:0]       xbar_selectors_a_out,
   output logic [1:0]       xbar_selectors_b_out,
   output logic [1:0]       xbar_selectors_c_out,
   output logic [1:0]       xbar_selectors_d_out,
   output logic             xbar_oe_out,
   output logic             commit_pulse_out,
   output logic             pending_out
);
   // Timer counts load value down to zero; done is seen on the last cycle
   // of a half-window, so load BLANK_CYCLES-1 to get BLANK_CYCLES cycles.
   localparam logic [7:0] BLANK_LD = 8'(BLANK_CYCLES - 1);

   state_e           state_q, state_d;
   sel_vec_t         shadow_q, shadow_d;
   sel_vec_t         active_q, active_d;
   logic [ROT_W-1:0] fcnt_q, fcnt_d;
   logic             pending_q, pending_d;
   logic             commit_q, commit_d;
   logic             open_q, open_d;
   logic             tmr_load, tmr_done;
   logic             accept, step;
   logic [ROT_W-1:0] per_m1;

   xbar_blank_timer u_timer (
      .clk_i      (clk_in),
      .rst_ni     (rst_n_in),
      .load_i     (tmr_load),
      .load_val_i (BLANK_LD),
      .done_o     (tmr_done)
   );

   assign per_m1 = (rotate_period_in == '0) ? '0 : rotate_period_in - ROT_W'(1);

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      fcnt_d    = fcnt_q;
      pending_d = pending_q;
      commit_d  = 1'b0;
      tmr_load  = 1'b0;
      accept    = 1'b0;
      step      = 1'b0;

      if (!rotate_en_in) fcnt_d = '0;

      case (state_q)
         ST_IDLE, ST_PEND: begin
            accept = cfg_valid_in && open_q;
            // >= rather than == so a period lowered mid-count still fires
            // on the next frame instead of waiting for counter wrap.
            if (rotate_en_in && frame_sync_in) begin
               if (fcnt_q >= per_m1) begin
                  fcnt_d = '0;
                  step   = 1'b1;
               end else begin
                  fcnt_d = fcnt_q + ROT_W'(1);
               end
            end
            // Rotate first so a same-cycle write lands unrotated.
            if (step) begin
               for (int i = 0; i < XBAR_PORTS; i++) shadow_d[i] = shadow_q[i] + 2'd1;
               pending_d = 1'b1;
            end
            if (accept) begin
               shadow_d[cfg_out_idx_in] = cfg_src_in;
               pending_d                = 1'b1;
               state_d                  = ST_PEND;
            end
            if (step || (frame_sync_in && state_q == ST_PEND)) begin
               state_d  = ST_BLANK_PRE;
               tmr_load = 1'b1;
            end
         end
         ST_BLANK_PRE: begin
            if (tmr_done) begin
               active_d  = shadow_q;
               commit_d  = 1'b1;
               pending_d = 1'b0;
               state_d   = ST_BLANK_POST;
               tmr_load  = 1'b1;
            end
         end
         ST_BLANK_POST: begin
            if (tmr_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Output enable and write-ready are both "not blanking".
      open_d = (state_d == ST_IDLE) || (state_d == ST_PEND);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= ST_IDLE;
         shadow_q  <= SEL_IDENTITY;
         active_q  <= SEL_IDENTITY;
         fcnt_q    <= '0;
         pending_q <= 1'b0;
         commit_q  <= 1'b0;
         open_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         fcnt_q    <= fcnt_d;
         pending_q <= pending_d;
         commit_q  <= commit_d;
         open_q    <= open_d;
      end
   end

   assign cfg_ready_out        = open_q;
   assign xbar_oe_out          = open_q;
   assign commit_pulse_out     = commit_q;
   assign pending_out          = pending_q;
   assign xbar_selectors_a_out = active_q[0];
   assign xbar_selectors_b_out = active_q[1];
   assign xbar_selectors_c_out = active_q[2];
   assign xbar_selectors_d_out = active_q[3];
endmodule

// File: tb/tb_xbar_route_sched.sv
// Bench for xbar_route_sched: timing-based reference model, commit
// scoreboard, directed scenarios and a randomized phase.
module tb_xbar_route_sched;
   localparam int B = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cfg_valid = 1'b0;
   logic [1:0]  cfg_idx = 2'd0, cfg_src = 2'd0;
   logic        frame_sync = 1'b0, rotate_en = 1'b0;
   logic [15:0] rotate_period = 16'd0;
   logic        cfg_ready, oe, commit, pend;
   logic [1:0]  sa, sb, sc, sd;

   xbar_route_sched #(.BLANK_CYCLES(B), .ROT_W(16)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .cfg_valid_in(cfg_valid), .cfg_ready_out(cfg_ready),
      .cfg_out_idx_in(cfg_idx), .cfg_src_in(cfg_src), .frame_sync_in(frame_sync),
      .rotate_en_in(rotate_en), .rotate_period_in(rotate_period),
      .xbar_selectors_a_out(sa), .xbar_selectors_b_out(sb), .xbar_selectors_c_out(sc),
      .xbar_selectors_d_out(sd), .xbar_oe_out(oe), .commit_pulse_out(commit), .pending_out(pend));

   always #5 clk = ~clk;

   typedef struct { logic [7:0] sel; int cyc; } exp_t;
   exp_t sbq[$];

   int n_chk = 0, n_pass = 0, n_commit = 0;
   int cyc = 0;
   bit started = 1'b0;

   function automatic logic [7:0] pk(input int a, input int b, input int c, input int d);
      logic [1:0] xa, xb, xc, xd;
      xa = a[1:0]; xb = b[1:0]; xc = c[1:0]; xd = d[1:0];
      return {xa, xb, xc, xd};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   // Blanking is tracked as a window of cycle numbers around the trigger
   // cycle trig: closed for trig+1..trig+2B, swap at the end of trig+B.
   int m_sh[4], m_act[4];
   int m_fcnt = 0, trig = -1000;
   bit m_pend = 1'b0;
   logic [11:0] exp_vec = {4'b1100, 8'b00_01_10_11};

   initial begin
      for (int i = 0; i < 4; i++) begin m_sh[i] = i; m_act[i] = i; end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin m_sh[i] = i; m_act[i] = i; end
            m_pend = 1'b0; m_fcnt = 0; trig = -1000;
            sbq.delete();
            exp_vec = {4'b1100, pk(0, 1, 2, 3)};
         end else begin
            int k, per;
            bit open, step, old_pend, e_oe, e_cm;
            k = cyc;
            open = !(k >= trig + 1 && k <= trig + 2 * B);
            step = 1'b0;
            if (!rotate_en) m_fcnt = 0;
            if (open) begin
               old_pend = m_pend;
               if (rotate_en && frame_sync) begin
                  per = (rotate_period == 0) ? 1 : int'(rotate_period);
                  if (m_fcnt >= per - 1) begin m_fcnt = 0; step = 1'b1; end
                  else m_fcnt++;
               end
               if (step) for (int i = 0; i < 4; i++) m_sh[i] = (m_sh[i] + 1) % 4;
               if (cfg_valid) begin m_sh[cfg_idx] = int'(cfg_src); m_pend = 1'b1; end
               if (step) m_pend = 1'b1;
               if (step || (frame_sync && old_pend)) begin
                  trig = k;
                  sbq.push_back('{sel: pk(m_sh[0], m_sh[1], m_sh[2], m_sh[3]), cyc: k + B + 1});
               end
            end else if (k == trig + B) begin
               m_act = m_sh;
               m_pend = 1'b0;
            end
            cyc = k + 1;
            e_oe = !(cyc >= trig + 1 && cyc <= trig + 2 * B);
            e_cm = (cyc == trig + B + 1);
            exp_vec = {e_oe, e_oe, m_pend, e_cm, pk(m_act[0], m_act[1], m_act[2], m_act[3])};
         end
      end
   end

   // ---------------- monitor ----------------
   initial forever begin
      @(negedge clk);
      if (started && rst_n) begin
         chk("cycle_outputs", {20'd0, oe, cfg_ready, pend, commit, sa, sb, sc, sd}, {20'd0, exp_vec});
         if (commit) begin
            n_commit++;
            if (sbq.size() == 0) begin
               n_chk++;
               $display("FAIL commit_unexpected: commit pulse with sel %h, none expected (cycle %0d)",
                        {sa, sb, sc, sd}, cyc);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("commit_sel", {24'd0, sa, sb, sc, sd}, {24'd0, e.sel});
               chk("commit_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk); #2 rst_n = 1'b0;
      @(negedge clk); #2 rst_n = 1'b1;
   endtask

   task automatic wr(input logic [1:0] i, input logic [1:0] s);
      int n;
      n = 0;
      @(negedge clk); cfg_valid = 1'b1; cfg_idx = i; cfg_src = s;
      while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin n_chk++; $display("FAIL write_timeout: ready never seen, limit 50 cycles"); end
      @(negedge clk); cfg_valid = 1'b0;
   endtask

   task automatic pulse_sync();
      @(negedge clk); frame_sync = 1'b1;
      @(negedge clk); frame_sync = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      #1 rst_n = 1'b0;
      tick(2);
      #2 rst_n = 1'b1;
      started = 1'b1;

      // reset state
      @(negedge clk);
      chk("reset_sel", {24'd0, sa, sb, sc, sd}, {24'd0, pk(0, 1, 2, 3)});
      chk("reset_flags", {29'd0, oe, cfg_ready, pend}, {29'd0, 3'b110});

      // deferred commit + backpressure
      wr(2'd0, 2'd3);
      wr(2'd2, 2'd0);
      tick(10);
      chk("defer_sel_unchanged", {24'd0, sa, sb, sc, sd}, {24'd0, pk(0, 1, 2, 3)});
      chk("defer_pending", {31'd0, pend}, 32'd1);
      @(negedge clk); frame_sync = 1'b1;                 // cycle T
      @(negedge clk); frame_sync = 1'b0;                 // T+1
      cfg_valid = 1'b1; cfg_idx = 2'd1; cfg_src = 2'd2;
      chk("blank_ready_low", {31'd0, cfg_ready}, 32'd0);
      tick(B);                                           // T+B+1
      chk("defer_commit_sel", {24'd0, sa, sb, sc, sd}, {24'd0, pk(3, 1, 0, 3)});
      chk("defer_commit_pulse", {31'd0, commit}, 32'd1);
      tick(B);                                           // T+2B+1
      chk("reopen_flags", {30'd0, oe, cfg_ready}, 32'd3);
      @(negedge clk); cfg_valid = 1'b0;                  // T+2B+2
      chk("backpressure_pending", {31'd0, pend}, 32'd1);
      pulse_sync();
      tick(2 * B + 2);

      // rotation, period 2
      do_reset();
      @(negedge clk); rotate_en = 1'b1; rotate_period = 16'd2;
      pulse_sync(); tick(3);
      chk("rot_first_sync", {24'd0, sa, sb, sc, sd}, {24'd0, pk(0, 1, 2, 3)});
      pulse_sync(); tick(2 * B + 2);
      chk("rot_second_sync", {24'd0, sa, sb, sc, sd}, {24'd0, pk(1, 2, 3, 0)});
      pulse_sync(); tick(3);
      pulse_sync(); tick(2 * B + 2);
      chk("rot_fourth_sync", {24'd0, sa, sb, sc, sd}, {24'd0, pk(2, 3, 0, 1)});

      // rotate + write collision, period 1
      do_reset();
      @(negedge clk); rotate_en = 1'b1; rotate_period = 16'd1;
      @(negedge clk); frame_sync = 1'b1; cfg_valid = 1'b1; cfg_idx = 2'd1; cfg_src = 2'd0;
      @(negedge clk); frame_sync = 1'b0; cfg_valid = 1'b0;
      tick(2 * B + 2);
      chk("collision_sel", {24'd0, sa, sb, sc, sd}, {24'd0, pk(1, 0, 3, 0)});
      rotate_en = 1'b0;

      // reset during BLANK_PRE
      do_reset();
      wr(2'd0, 2'd2);
      pulse_sync();                                      // now T+1
      @(negedge clk);                                    // T+2
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_sel", {24'd0, sa, sb, sc, sd}, {24'd0, pk(0, 1, 2, 3)});
      chk("midreset_flags", {29'd0, oe, cfg_ready, pend}, {29'd0, 3'b110});
      c0 = n_commit;
      @(negedge clk); #2 rst_n = 1'b1;
      tick(2 * B + 4);
      chk("midreset_no_commit", n_commit, c0);

      // randomized phase
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (c % 60 == 0) begin
            rotate_en = 1'b0;
            rotate_period = 16'($urandom_range(0, 3));
         end else if (c % 60 == 1) begin
            rotate_en = 1'($urandom_range(0, 1));
         end
         cfg_valid  = ($urandom_range(0, 99) < 30);
         cfg_idx    = 2'($urandom_range(0, 3));
         cfg_src    = 2'($urandom_range(0, 3));
         frame_sync = ($urandom_range(0, 99) < 12);
         if (c == 300) begin #2 rst_n = 1'b0; end
         if (c == 301) begin #2 rst_n = 1'b1; end
      end
      @(negedge clk);
      cfg_valid = 1'b0; frame_sync = 1'b0; rotate_en = 1'b0;
      tick(3 * B + 4);
      chk("scoreboard_drained", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
